// File: rtl/xge_fault_pkg.sv
// Shared XGMII link-fault types for the TX fault controller and the RX fault detector.
package xge_fault_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FAULT   = 2'd2,
    ST_HOLDOFF = 2'd3
  } tx_fault_state_e;

  typedef enum logic [1:0] {
    LINK_FAULT_OK     = 2'd0,
    LINK_FAULT_LOCAL  = 2'd1,
    LINK_FAULT_REMOTE = 2'd2
  } link_fault_e;

  // Local fault outranks remote; with neither present the previous type is kept.
  function automatic link_fault_e link_fault_encode(input logic          local_flt,
                                                    input logic          remote_flt,
                                                    input link_fault_e   prev);
    link_fault_e enc;
    if (local_flt) begin
      enc = LINK_FAULT_LOCAL;
    end else if (remote_flt) begin
      enc = LINK_FAULT_REMOTE;
    end else begin
      enc = prev;
    end
    return enc;
  endfunction

endpackage

// File: rtl/tx_fault_ctrl.sv
// TX link-fault sequencer: drains the in-flight frame, inserts RF/Idle, then holds off before resuming.
// Optional macro TX_FAULT_STATS_EN adds the saturating fault_entry_cnt output.
module tx_fault_ctrl
  import xge_fault_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx_n,
  input  logic        status_local_fault_ctx,
  input  logic        status_remote_fault_ctx,
  input  logic        frame_active,
  input  logic        frame_eop,
  output logic        tx_inhibit_sop,
  output logic        tx_insert_rf,
  output logic        tx_insert_idle,
  output logic [1:0]  fault_state
`ifdef TX_FAULT_STATS_EN
  ,
  output logic [15:0] fault_entry_cnt
`endif
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  tx_fault_state_e state_r;
  tx_fault_state_e state_nxt_s;
  logic [7:0]      hold_cnt_r;
  logic [7:0]      hold_cnt_nxt_s;
  link_fault_e     fault_type_r;
  link_fault_e     fault_type_nxt_s;
  logic            fault_any_s;

  assign fault_any_s = status_local_fault_ctx | status_remote_fault_ctx;

  // Next-state and holdoff counter logic.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    case (state_r)
      ST_NORMAL: begin
        if (fault_any_s) begin
          if (frame_active && !frame_eop) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end else begin
          state_nxt_s = ST_NORMAL;
        end
      end
      ST_DRAIN: begin
        if (frame_eop) begin
          state_nxt_s = ST_FAULT;
        end else if (!fault_any_s) begin
          state_nxt_s = ST_NORMAL;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_FAULT: begin
        if (!fault_any_s) begin
          state_nxt_s    = ST_HOLDOFF;
          hold_cnt_nxt_s = HOLD_LOAD;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      ST_HOLDOFF: begin
        if (fault_any_s) begin
          state_nxt_s = ST_FAULT;
        end else if (hold_cnt_r == 8'd0) begin
          state_nxt_s = ST_NORMAL;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_NORMAL;
      end
    endcase
  end

  // Fault type is captured on the way into ST_FAULT too, so the first fault cycle already inserts the right pattern.
  always_comb begin
    if (state_nxt_s == ST_FAULT) begin
      fault_type_nxt_s = link_fault_encode(status_local_fault_ctx, status_remote_fault_ctx, fault_type_r);
    end else begin
      fault_type_nxt_s = fault_type_r;
    end
  end

  // State, holdoff counter and fault type registers.
  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      state_r      <= ST_NORMAL;
      hold_cnt_r   <= 8'd0;
      fault_type_r <= LINK_FAULT_OK;
    end else begin
      state_r      <= state_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      fault_type_r <= fault_type_nxt_s;
    end
  end

  assign tx_inhibit_sop = (state_r != ST_NORMAL);
  assign tx_insert_rf   = (state_r == ST_FAULT) && (fault_type_r == LINK_FAULT_LOCAL);
  assign tx_insert_idle = (state_r == ST_HOLDOFF) ||
                          ((state_r == ST_FAULT) && (fault_type_r == LINK_FAULT_REMOTE));
  assign fault_state    = state_r;

`ifdef TX_FAULT_STATS_EN
  logic [15:0] entry_cnt_r;

  // Saturating count of exits from normal operation.
  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      entry_cnt_r <= 16'd0;
    end else if ((state_r == ST_NORMAL) && (state_nxt_s != ST_NORMAL) && (entry_cnt_r != 16'hFFFF)) begin
      entry_cnt_r <= entry_cnt_r + 16'd1;
    end else begin
      entry_cnt_r <= entry_cnt_r;
    end
  end

  assign fault_entry_cnt = entry_cnt_r;
`endif

endmodule

// File: tb/tb_tx_fault_ctrl.sv
// Scoreboard bench for tx_fault_ctrl: a reference model pushes expected outputs per driven cycle,
// a monitor pops and compares them; scenario tasks add directed timing checks.
module tb_tx_fault_ctrl;

  localparam int HOLD = 16;

  logic        clk_xgmii_tx = 1'b0;
  logic        reset_xgmii_tx_n;
  logic        status_local_fault_ctx;
  logic        status_remote_fault_ctx;
  logic        frame_active;
  logic        frame_eop;
  logic        tx_inhibit_sop;
  logic        tx_insert_rf;
  logic        tx_insert_idle;
  logic [1:0]  fault_state;
  logic [15:0] cnt_obs;

  typedef struct packed {
    logic        inh;
    logic        rf;
    logic        idle;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int   m_state   = 0;
  int   m_cnt     = 0;
  int   m_type    = 0;
  int   m_entries = 0;

  tx_fault_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk_xgmii_tx            (clk_xgmii_tx),
    .reset_xgmii_tx_n        (reset_xgmii_tx_n),
    .status_local_fault_ctx  (status_local_fault_ctx),
    .status_remote_fault_ctx (status_remote_fault_ctx),
    .frame_active            (frame_active),
    .frame_eop               (frame_eop),
    .tx_inhibit_sop          (tx_inhibit_sop),
    .tx_insert_rf            (tx_insert_rf),
    .tx_insert_idle          (tx_insert_idle),
    .fault_state             (fault_state)
`ifdef TX_FAULT_STATS_EN
    ,
    .fault_entry_cnt         (cnt_obs)
`endif
  );

`ifndef TX_FAULT_STATS_EN
  assign cnt_obs = 16'd0;
`endif

  always #5 clk_xgmii_tx = ~clk_xgmii_tx;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_state   = 0;
    m_cnt     = 0;
    m_type    = 0;
    m_entries = 0;
    sb_q.delete();
  endtask

  // Reference behaviour: state names 0=normal 1=drain 2=fault 3=holdoff, type 1=local 2=remote.
  task automatic model_step(input logic l, input logic r, input logic a, input logic e);
    exp_t x;
    bit   flt;
    int   nst;
    flt = l || r;
    nst = m_state;
    if (m_state == 0) begin
      if (flt) nst = (a && !e) ? 1 : 2;
    end else if (m_state == 1) begin
      if (e) nst = 2;
      else if (!flt) nst = 0;
    end else if (m_state == 2) begin
      if (!flt) begin
        nst   = 3;
        m_cnt = HOLD - 1;
      end
    end else begin
      if (flt) nst = 2;
      else if (m_cnt == 0) nst = 0;
      else m_cnt = m_cnt - 1;
    end
    if (nst == 2) begin
      if (l) m_type = 1;
      else if (r) m_type = 2;
    end
    if (m_state == 0 && nst != 0 && m_entries < 65535) m_entries++;
    m_state = nst;
    x.st   = 2'(nst);
    x.inh  = (nst != 0);
    x.rf   = (nst == 2) && (m_type == 1);
    x.idle = (nst == 3) || ((nst == 2) && (m_type == 2));
    x.cnt  = 16'(m_entries);
    sb_q.push_back(x);
  endtask

  task automatic drive(input logic l, input logic r, input logic a, input logic e);
    status_local_fault_ctx  = l;
    status_remote_fault_ctx = r;
    frame_active            = a;
    frame_eop               = e;
    model_step(l, r, a, e);
    @(posedge clk_xgmii_tx);
    #2;
  endtask

  // Scoreboard monitor: one expectation per driven cycle, checked just after the edge.
  always @(posedge clk_xgmii_tx) begin : monitor
    exp_t e;
    exp_t g;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g.inh  = tx_inhibit_sop;
      g.rf   = tx_insert_rf;
      g.idle = tx_insert_idle;
      g.st   = fault_state;
`ifdef TX_FAULT_STATS_EN
      g.cnt  = cnt_obs;
`else
      g.cnt  = e.cnt;
`endif
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got inh=%b rf=%b idle=%b st=%0d cnt=%0d, want inh=%b rf=%b idle=%b st=%0d cnt=%0d",
                 $time, g.inh, g.rf, g.idle, g.st, g.cnt, e.inh, e.rf, e.idle, e.st, e.cnt);
      end
    end
  end

  task automatic recover();
    for (int i = 0; i < HOLD + 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic count_holdoff(output int n);
    n = 0;
    while (fault_state == 2'd3 && n < 40) begin
      n++;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset_xgmii_tx_n        = 1'b0;
    status_local_fault_ctx  = 1'b0;
    status_remote_fault_ctx = 1'b0;
    frame_active            = 1'b0;
    frame_eop               = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_xgmii_tx);
    #1;
    vectors++;
    if ({tx_inhibit_sop, tx_insert_rf, tx_insert_idle, fault_state} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b, want 00000", {tx_inhibit_sop, tx_insert_rf, tx_insert_idle, fault_state});
    end
    @(negedge clk_xgmii_tx);
    reset_xgmii_tx_n = 1'b1;
  endtask

  task automatic test_local_fault();
    for (int c = 0; c < 10; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({fault_state, tx_insert_rf, tx_inhibit_sop, tx_insert_idle} !== 5'b10_110) begin
      miscompares++;
      $display("FAIL local_entry got st=%0d rf=%b inh=%b idle=%b, want st=2 rf=1 inh=1 idle=0",
               fault_state, tx_insert_rf, tx_inhibit_sop, tx_insert_idle);
    end
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b1);
    recover();
  endtask

  task automatic test_drain();
    for (int c = 0; c < 5; c++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 5; c < 9; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (fault_state !== 2'd1 || tx_insert_idle !== 1'b0 || tx_insert_rf !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_hold got st=%0d idle=%b rf=%b, want st=1 idle=0 rf=0", fault_state, tx_insert_idle, tx_insert_rf);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (fault_state !== 2'd2 || tx_insert_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_eop got st=%0d idle=%b, want st=2 idle=1", fault_state, tx_insert_idle);
    end
  endtask

  task automatic test_holdoff();
    int n;
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    count_holdoff(n);
    vectors++;
    if (n !== HOLD || fault_state !== 2'd0 || tx_inhibit_sop !== 1'b0) begin
      miscompares++;
      $display("FAIL holdoff_len got cycles=%0d st=%0d inh=%b, want cycles=%0d st=0 inh=0", n, fault_state, tx_inhibit_sop, HOLD);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (fault_state !== 2'd2) begin
      miscompares++;
      $display("FAIL holdoff_refault got st=%0d, want 2", fault_state);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    count_holdoff(n);
    vectors++;
    if (n !== HOLD) begin
      miscompares++;
      $display("FAIL holdoff_reload got cycles=%0d, want %0d", n, HOLD);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (tx_insert_rf !== 1'b1 || tx_insert_idle !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_both got rf=%b idle=%b, want rf=1 idle=0", tx_insert_rf, tx_insert_idle);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (tx_insert_rf !== 1'b0 || tx_insert_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_remote got rf=%b idle=%b, want rf=0 idle=1", tx_insert_rf, tx_insert_idle);
    end
    recover();
  endtask

  task automatic test_drain_exits();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (fault_state !== 2'd0) begin
      miscompares++;
      $display("FAIL drain_abort got st=%0d, want 0", fault_state);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (fault_state !== 2'd2) begin
      miscompares++;
      $display("FAIL drain_eop_wins got st=%0d, want 2", fault_state);
    end
    recover();
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (fault_state !== 2'd2) begin
      miscompares++;
      $display("FAIL normal_eop_direct got st=%0d, want 2", fault_state);
    end
    recover();
  endtask

  task automatic test_random();
    logic l = 1'b0;
    logic r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) l = ~l;
      if ($urandom_range(0, 19) == 0) r = ~r;
      drive(l, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
    recover();
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    reset_xgmii_tx_n = 1'b0;
    #1;
    vectors++;
    if ({tx_inhibit_sop, tx_insert_rf, tx_insert_idle, fault_state} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_in_drain got %b, want 00000", {tx_inhibit_sop, tx_insert_rf, tx_insert_idle, fault_state});
    end
    model_reset();
    status_active_clear();
    repeat (2) @(posedge clk_xgmii_tx);
    @(negedge clk_xgmii_tx);
    reset_xgmii_tx_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (fault_state !== 2'd2) begin
      miscompares++;
      $display("FAIL post_reset_fresh got st=%0d, want 2", fault_state);
    end
    recover();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    recover();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    recover();
`ifdef TX_FAULT_STATS_EN
    vectors++;
    if (cnt_obs !== 16'd3) begin
      miscompares++;
      $display("FAIL entry_count got %0d, want 3", cnt_obs);
    end
`endif
  endtask

  task automatic status_active_clear();
    frame_active = 1'b0;
    frame_eop    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_local_fault();
    test_drain();
    test_holdoff();
    recover();
    test_priority();
    test_drain_exits();
    test_random();
    test_reset_mid_drain();
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_fault_ctrl.md
TX_FAULT_CTRL -- requirements
Module: tx_fault_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, meaning the number of fault-free cycles required before normal transmission resumes; legal range 1..255.
REQ-002 SHALL have clk_xgmii_tx  input  1  TX XGMII clock; all logic runs on its rising edge.
REQ-003 SHALL have reset_xgmii_tx_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have status_local_fault_ctx  input  1  local fault status, already synchronized to clk_xgmii_tx.
REQ-005 SHALL have status_remote_fault_ctx  input  1  remote fault status, already synchronized to clk_xgmii_tx.
REQ-006 SHALL have frame_active  input  1  TX datapath is between SOP and EOP.
REQ-007 SHALL have frame_eop  input  1  TX datapath emits EOP this cycle.
REQ-008 SHALL have tx_inhibit_sop  output  1  the dequeue logic must not start a new frame.
REQ-009 SHALL have tx_insert_rf  output  1  replace output columns with Remote Fault ordered sets.
REQ-010 SHALL have tx_insert_idle  output  1  replace output columns with Idle.
REQ-011 SHALL have fault_state  output  2  current state, for debug.

Function
REQ-012 SHALL implement four states: ST_NORMAL=0, ST_DRAIN=1, ST_FAULT=2, ST_HOLDOFF=3.
REQ-013 SHALL define fault_any = status_local_fault_ctx | status_remote_fault_ctx.
REQ-014 SHALL, in ST_NORMAL with fault_any, go to ST_DRAIN if frame_active=1 and frame_eop=0; otherwise go to ST_FAULT.
REQ-015 SHALL, in ST_DRAIN:
- go to ST_FAULT on frame_eop=1;
- go to ST_NORMAL if fault_any=0 and frame_eop=0;
- when both conditions occur together, frame_eop wins.
REQ-016 SHALL, in ST_FAULT with fault_any=0, go to ST_HOLDOFF and load hold_cnt with HOLD_CYCLES-1.
REQ-017 SHALL, in ST_HOLDOFF:
- go to ST_FAULT if fault_any=1;
- else go to ST_NORMAL if hold_cnt=0;
- else decrement hold_cnt.
REQ-018 SHALL make hold_cnt 8 bits wide, decrement only in ST_HOLDOFF, and never wrap below 0.
REQ-019 SHALL decode outputs combinationally from the state register, giving one-cycle latency from input sample to output.
REQ-020 SHALL assert tx_inhibit_sop in every state except ST_NORMAL.
REQ-021 SHALL assert tx_insert_rf only in ST_FAULT while status_local_fault_ctx is registered high (fault_type=LOCAL); local fault takes priority over remote.
REQ-022 SHALL assert tx_insert_idle in ST_HOLDOFF, and in ST_FAULT when fault_type=REMOTE.
REQ-023 SHALL register fault_type each cycle in ST_FAULT, encoded LINK_FAULT_LOCAL if local, else LINK_FAULT_REMOTE if remote, else hold the previous value.
REQ-024 SHALL never assert tx_insert_rf and tx_insert_idle in the same cycle.
REQ-025 SHALL never assert tx_insert_rf or tx_insert_idle in ST_DRAIN, so the in-flight frame completes intact.
REQ-026 SHALL ignore frame_eop and frame_active in ST_FAULT and ST_HOLDOFF.

Reset
REQ-027 SHALL, on reset assertion and regardless of clock, set state=ST_NORMAL, hold_cnt=0 and fault_type=LINK_FAULT_OK.
REQ-028 SHALL drive tx_inhibit_sop=0, tx_insert_rf=0, tx_insert_idle=0 and fault_state=0 during reset.
REQ-029 SHALL, on reset mid-drain or mid-holdoff, abandon the sequence; the first post-reset cycle evaluates REQ-014 afresh.

Configuration
REQ-030 SHALL, with macro TX_FAULT_STATS_EN defined:
- add output fault_entry_cnt, 16 bits;
- increment it on each ST_NORMAL->ST_DRAIN or ST_NORMAL->ST_FAULT transition;
- saturate it at 16'hFFFF;
- reset it to 0.
REQ-031 SHALL, without TX_FAULT_STATS_EN, omit the fault_entry_cnt port and counter entirely.

Structure
REQ-032 SHALL place the state enumeration and LINK_FAULT_OK/LOCAL/REMOTE encodings in shared package xge_fault_pkg, also used by the RX fault detector.
REQ-033 SHALL be a single module; no sub-module is warranted.

Verification
REQ-034 SHALL cover: idle link, assert local fault at cycle 10, frame_active=0 -> ST_FAULT at cycle 11, tx_insert_rf=1 and tx_inhibit_sop=1 from cycle 11.
REQ-035 SHALL cover: frame_active=1, remote fault at cycle 5, frame_eop at cycle 9 -> ST_DRAIN cycles 6..9, tx_insert_idle=0 through cycle 9, tx_insert_idle=1 from cycle 10.
REQ-036 SHALL cover: in ST_FAULT, deassert fault at cycle 20 with HOLD_CYCLES=16 -> tx_insert_idle=1 through cycle 36, ST_NORMAL and tx_inhibit_sop=0 at cycle 37.
REQ-037 SHALL cover: in ST_HOLDOFF with hold_cnt=5, reassert remote fault -> ST_FAULT next cycle; fault clears -> hold_cnt reloads to 15.
REQ-038 SHALL cover: local and remote asserted together -> tx_insert_rf=1, tx_insert_idle=0; drop local only -> tx_insert_idle=1 next cycle.
REQ-039 SHALL cover: reset asserted in ST_DRAIN -> all outputs 0 immediately; with TX_FAULT_STATS_EN, 3 fault entries -> fault_entry_cnt=3.
